// File: rtl/prog_loader_if.sv
// Byte-stream download and instruction-memory write bus for prog_loader.
// The loader side is the master: it consumes the byte stream and drives the memory write port.
interface prog_loader_if #(
    parameter int IM_SIZE = 8,
    parameter int INSTR_W = 16
);
    logic               byte_valid;
    logic [7:0]         byte_data;
    logic               byte_ready;
    logic               imem_we;
    logic [IM_SIZE-1:0] imem_addr;
    logic [INSTR_W-1:0] imem_din;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_din
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_din
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: receives a length byte followed by big-endian instruction words,
// writes them to instruction memory, and holds the CPU in reset until the image is complete.
module prog_loader #(
    parameter int IM_SIZE = 8,
    parameter int INSTR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load_start,
    input  logic              i_abort,
    prog_loader_if.master     bus,
    output logic              o_cpu_rst,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        HI,
        LO,
        WR,
        RUN
    } state_t;

    localparam logic [IM_SIZE:0]   CNT_ONE  = (IM_SIZE+1)'(1);
    localparam logic [IM_SIZE-1:0] ADDR_ONE = IM_SIZE'(1);

    state_t             r_state;
    logic [IM_SIZE:0]   r_count;
    logic [IM_SIZE-1:0] r_addr;
    logic [INSTR_W-1:0] r_din;
    logic               r_done;

    logic               w_ready;
    logic               w_xfer;
    logic               w_last;
    logic [IM_SIZE:0]   w_lenCount;

    assign w_ready = (r_state == LEN) || (r_state == HI) || (r_state == LO);
    assign w_xfer  = w_ready && bus.byte_valid && !i_abort;
    assign w_last  = ({1'b0, r_addr} == (r_count - CNT_ONE));

    // A length byte of zero stands for a full memory image of 2^IM_SIZE words.
    always_comb begin
        w_lenCount = '0;
        if (bus.byte_data == 8'h00) begin
            w_lenCount[IM_SIZE] = 1'b1;
        end else begin
            w_lenCount = (IM_SIZE+1)'(bus.byte_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_addr  <= '0;
            r_din   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_load_start) r_state <= LEN;
                end
                LEN: begin
                    if (i_abort) begin
                        r_state <= IDLE;
                    end else if (w_xfer) begin
                        r_count <= w_lenCount;
                        r_addr  <= '0;
                        r_state <= HI;
                    end
                end
                HI: begin
                    if (i_abort) begin
                        r_state <= IDLE;
                    end else if (w_xfer) begin
                        r_din[INSTR_W-1:INSTR_W-8] <= bus.byte_data;
                        r_state <= LO;
                    end
                end
                LO: begin
                    if (i_abort) begin
                        r_state <= IDLE;
                    end else if (w_xfer) begin
                        r_din[7:0] <= bus.byte_data;
                        r_state    <= WR;
                    end
                end
                WR: begin
                    if (i_abort) begin
                        r_state <= IDLE;
                    end else if (w_last) begin
                        r_state <= RUN;
                        r_done  <= 1'b1;
                    end else begin
                        r_addr  <= r_addr + ADDR_ONE;
                        r_state <= HI;
                    end
                end
                RUN: begin
                    if (i_load_start) r_state <= LEN;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The write strobe is gated by abort so a cancelled word never reaches memory.
    assign bus.byte_ready = w_ready;
    assign bus.imem_we    = (r_state == WR) && !i_abort;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_din   = r_din;
    assign o_cpu_rst      = (r_state != RUN);
    assign o_busy         = (r_state == LEN) || (r_state == HI) || (r_state == LO) || (r_state == WR);
    assign o_done         = r_done;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table-driven downloads, randomized streams against a
// stream-level reference model, and hand-written abort/reset sequences.
module tb_prog_loader;

    localparam int IM_SIZE = 8;
    localparam int INSTR_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic loadStart = 1'b0;
    logic abortIn = 1'b0;
    logic cpuRst;
    logic busy;
    logic done;

    prog_loader_if #(.IM_SIZE(IM_SIZE), .INSTR_W(INSTR_W)) bus ();

    prog_loader #(.IM_SIZE(IM_SIZE), .INSTR_W(INSTR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load_start (loadStart),
        .i_abort      (abortIn),
        .bus          (bus),
        .o_cpu_rst    (cpuRst),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic [7:0]        len;
        int                nWords;
        logic [3:0][15:0]  words;
        int                gapMax;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int fails = 0;

    logic [7:0]  wrAddr[$];
    logic [15:0] wrData[$];
    logic [15:0] mem[256];
    int          doneCnt = 0;

    logic [7:0]  stream[$];
    logic [7:0]  expAddr[$];
    logic [15:0] expData[$];

    // Acts as the instruction memory and logs every write and done pulse.
    always @(negedge clk) begin
        if (rst_n && bus.imem_we) begin
            wrAddr.push_back(bus.imem_addr);
            wrData.push_back(bus.imem_din);
            mem[bus.imem_addr] = bus.imem_din;
        end
        if (rst_n && done) doneCnt++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expected);
        checks++;
        if (act !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expected);
        end
    endtask

    // Reference model: length byte then (hi, lo) pairs written to consecutive addresses from 0.
    task automatic buildExpected();
        int n;
        expAddr.delete();
        expData.delete();
        n = (stream[0] == 8'h00) ? 256 : int'(stream[0]);
        for (int i = 0; i < n; i++) begin
            expAddr.push_back(8'(i));
            expData.push_back({stream[1 + 2*i], stream[2 + 2*i]});
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input int gapMax);
        int gap;
        int waited;
        gap = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
        for (int g = 0; g < gap; g++) begin
            bus.byte_valid = 1'b0;
            bus.byte_data  = 8'($urandom);
            loadStart      = 1'($urandom_range(1, 0));
            @(posedge clk);
            #1;
        end
        loadStart      = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        waited = 0;
        @(negedge clk);
        while (!bus.byte_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.byte_ready) begin
            checkOutput("byte accept timeout", 32'(bus.byte_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic startLoad();
        loadStart = 1'b1;
        @(posedge clk);
        #1;
        loadStart = 1'b0;
    endtask

    task automatic finishCheck(input string tag, input int wrBase, input int doneBase);
        int waited;
        waited = 0;
        @(negedge clk);
        while (cpuRst && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, " reaches RUN"}, 32'(cpuRst), 32'd0);
        checkOutput({tag, " done on first RUN cycle"}, 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput({tag, " write count"}, wrAddr.size() - wrBase, expAddr.size());
        for (int i = 0; i < expAddr.size(); i++) begin
            if (wrBase + i < wrAddr.size()) begin
                checkOutput({tag, " write addr"}, 32'(wrAddr[wrBase + i]), 32'(expAddr[i]));
                checkOutput({tag, " write data"}, 32'(wrData[wrBase + i]), 32'(expData[i]));
            end
        end
        checkOutput({tag, " single done pulse"}, doneCnt - doneBase, 32'd1);
        checkOutput({tag, " busy low in RUN"}, 32'(busy), 32'd0);
        checkOutput({tag, " cpu_rst low in RUN"}, 32'(cpuRst), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input string tag, input int gapMax);
        int wrBase;
        int doneBase;
        wrBase   = wrAddr.size();
        doneBase = doneCnt;
        startLoad();
        checkOutput({tag, " busy after start"}, 32'(busy), 32'd1);
        checkOutput({tag, " cpu_rst after start"}, 32'(cpuRst), 32'd1);
        foreach (stream[i]) sendByte(stream[i], gapMax);
        finishCheck(tag, wrBase, doneBase);
    endtask

    task automatic addVec(input string nm, input logic [7:0] len, input int n,
                          input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                          input int gap);
        vec_t v;
        v.name     = nm;
        v.len      = len;
        v.nWords   = n;
        v.words    = '0;
        v.words[0] = w0;
        v.words[1] = w1;
        v.words[2] = w2;
        v.gapMax   = gap;
        vecs.push_back(v);
    endtask

    initial begin
        int wrBase;
        int doneBase;
        int n;

        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        addVec("basic",        8'h02, 2, 16'h1123, 16'hF100, 16'h0000, 0);
        addVec("gapped",       8'h02, 2, 16'h1123, 16'hF100, 16'h0000, 4);
        addVec("reload",       8'h01, 1, 16'hD000, 16'h0000, 16'h0000, 0);
        addVec("three words",  8'h03, 3, 16'hAA55, 16'h0001, 16'hFFFF, 2);

        #23;
        checkOutput("reset cpu_rst", 32'(cpuRst), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset byte_ready", 32'(bus.byte_ready), 32'd0);
        checkOutput("reset imem_we", 32'(bus.imem_we), 32'd0);
        checkOutput("reset imem_addr", 32'(bus.imem_addr), 32'd0);
        checkOutput("reset imem_din", 32'(bus.imem_din), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("cpu held in reset after release", 32'(cpuRst), 32'd1);
        checkOutput("idle not busy after release", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            stream.delete();
            expAddr.delete();
            expData.delete();
            stream.push_back(vecs[k].len);
            for (int i = 0; i < vecs[k].nWords; i++) begin
                stream.push_back(vecs[k].words[i][15:8]);
                stream.push_back(vecs[k].words[i][7:0]);
                expAddr.push_back(8'(i));
                expData.push_back(vecs[k].words[i]);
            end
            applyStimulus(vecs[k].name, vecs[k].gapMax);
        end

        for (int r = 0; r < 6; r++) begin
            stream.delete();
            n = int'($urandom_range(20, 1));
            stream.push_back(8'(n));
            for (int i = 0; i < 2*n; i++) stream.push_back(8'($urandom));
            buildExpected();
            applyStimulus("random", int'($urandom_range(3, 0)));
        end

        stream.delete();
        stream.push_back(8'h00);
        for (int i = 0; i < 512; i++) stream.push_back(8'($urandom));
        buildExpected();
        applyStimulus("full 256", 0);

        // Abort in LO of word 1 with a byte offered the same cycle.
        wrBase   = wrAddr.size();
        doneBase = doneCnt;
        startLoad();
        sendByte(8'h02, 0);
        sendByte(8'h11, 0);
        sendByte(8'h23, 0);
        sendByte(8'hF1, 0);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h00;
        abortIn        = 1'b1;
        @(posedge clk);
        #1;
        abortIn        = 1'b0;
        bus.byte_valid = 1'b0;
        checkOutput("abort LO goes idle", 32'(busy), 32'd0);
        checkOutput("abort LO cpu_rst held", 32'(cpuRst), 32'd1);
        repeat (4) @(negedge clk);
        checkOutput("abort LO write count", wrAddr.size() - wrBase, 32'd1);
        checkOutput("abort LO word0 retained", 32'(mem[0]), 32'h1123);
        checkOutput("abort LO no done", doneCnt - doneBase, 32'd0);
        checkOutput("abort LO still idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Abort while in WR must suppress the write strobe.
        wrBase = wrAddr.size();
        startLoad();
        sendByte(8'h01, 0);
        sendByte(8'hAB, 0);
        sendByte(8'hCD, 0);
        abortIn = 1'b1;
        @(negedge clk);
        checkOutput("abort WR no strobe", 32'(bus.imem_we), 32'd0);
        @(posedge clk);
        #1;
        abortIn = 1'b0;
        checkOutput("abort WR goes idle", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("abort WR write count", wrAddr.size() - wrBase, 32'd0);
        checkOutput("abort WR memory intact", 32'(mem[0]), 32'h1123);
        @(posedge clk);
        #1;

        // Asynchronous reset during HI of the second word.
        startLoad();
        sendByte(8'h02, 0);
        sendByte(8'h12, 0);
        sendByte(8'h34, 0);
        @(posedge clk);
        #1;
        checkOutput("pre-reset in HI", 32'(bus.byte_ready), 32'd1);
        checkOutput("pre-reset addr advanced", 32'(bus.imem_addr), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset busy", 32'(busy), 32'd0);
        checkOutput("async reset cpu_rst", 32'(cpuRst), 32'd1);
        checkOutput("async reset byte_ready", 32'(bus.byte_ready), 32'd0);
        checkOutput("async reset imem_we", 32'(bus.imem_we), 32'd0);
        checkOutput("async reset imem_addr", 32'(bus.imem_addr), 32'd0);
        checkOutput("async reset imem_din", 32'(bus.imem_din), 32'd0);
        checkOutput("async reset done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        stream.delete();
        stream.push_back(8'h03);
        for (int i = 0; i < 6; i++) stream.push_back(8'($urandom));
        buildExpected();
        applyStimulus("after reset", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
